// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding unit: operand-mux select codes and
// the per-stage destination tag carried down the EX/MEM/WB shadow pipeline.
package hazard_pkg;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,
        FWD_WB      = 2'b01,
        FWD_MEM     = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } stage_tag_t;
endpackage

// File: rtl/fwd_select.sv
// Picks the bypass source for one EX operand from the MEM/WB destination tags.
module fwd_select
    import hazard_pkg::*;
(
    input  logic                  ex_valid_in,
    input  logic [REG_ADDR_W-1:0] src_in,
    input  stage_tag_t            mem_tag_in,
    input  stage_tag_t            wb_tag_in,
    output fwd_sel_t              sel_out
);
    // WB forwards loads and ALU results alike, so its mem_read bit is not needed.
    logic unused_wb_load;
    assign unused_wb_load = wb_tag_in.mem_read;

    always_comb begin
        sel_out = FWD_REGFILE;
        if (!ex_valid_in) begin
            sel_out = FWD_REGFILE;
        end else if (mem_tag_in.valid && mem_tag_in.reg_write && !mem_tag_in.mem_read &&
                     mem_tag_in.rd != '0 && mem_tag_in.rd == src_in) begin
            sel_out = FWD_MEM;
        end else if (wb_tag_in.valid && wb_tag_in.reg_write &&
                     wb_tag_in.rd != '0 && wb_tag_in.rd == src_in) begin
            sel_out = FWD_WB;
        end
    end
endmodule

// File: rtl/hazard_forward_unit.sv
// Shadow tag pipeline for EX/MEM/WB: drives EX operand-mux selects, the
// load-use stall toward IF/ID and a saturating stall-cycle counter.
module hazard_forward_unit #(
    parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W,
    parameter int PERF_W     = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  id_valid_in,
    input  logic [REG_ADDR_W-1:0] id_rs1_in,
    input  logic [REG_ADDR_W-1:0] id_rs2_in,
    input  logic [REG_ADDR_W-1:0] id_rd_in,
    input  logic                  id_reg_write_in,
    input  logic                  id_mem_read_in,
    input  logic                  flush_in,
    input  logic                  freeze_in,
    output logic [1:0]            fwd_a_sel_out,
    output logic [1:0]            fwd_b_sel_out,
    output logic                  stall_out,
    output logic                  ex_valid_out,
    output logic [PERF_W-1:0]     stall_count_out
);
    import hazard_pkg::stage_tag_t;
    import hazard_pkg::fwd_sel_t;

    stage_tag_t            ex_tag_q, ex_tag_d;
    stage_tag_t            mem_tag_q, mem_tag_d;
    stage_tag_t            wb_tag_q, wb_tag_d;
    logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_ADDR_W-1:0] ex_rs2_q, ex_rs2_d;
    logic [PERF_W-1:0]     cnt_q, cnt_d;
    fwd_sel_t              fwd_a, fwd_b;
    logic                  stall;

    // rs2 is compared even when unused; the occasional extra stall is harmless.
    assign stall = id_valid_in && ex_tag_q.valid && ex_tag_q.mem_read && ex_tag_q.reg_write &&
                   ex_tag_q.rd != '0 && (ex_tag_q.rd == id_rs1_in || ex_tag_q.rd == id_rs2_in);

    always_comb begin
        ex_tag_d  = ex_tag_q;
        ex_rs1_d  = ex_rs1_q;
        ex_rs2_d  = ex_rs2_q;
        mem_tag_d = mem_tag_q;
        wb_tag_d  = wb_tag_q;
        cnt_d     = cnt_q;
        if (!freeze_in) begin
            wb_tag_d  = mem_tag_q;
            mem_tag_d = ex_tag_q;
            if (flush_in || stall || !id_valid_in) begin
                ex_tag_d = '0;
                ex_rs1_d = '0;
                ex_rs2_d = '0;
            end else begin
                ex_tag_d.valid     = 1'b1;
                ex_tag_d.rd        = id_rd_in;
                ex_tag_d.reg_write = id_reg_write_in;
                ex_tag_d.mem_read  = id_mem_read_in;
                ex_rs1_d           = id_rs1_in;
                ex_rs2_d           = id_rs2_in;
            end
            if (stall && !flush_in && cnt_q != '1)
                cnt_d = cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ex_tag_q  <= '0;
            ex_rs1_q  <= '0;
            ex_rs2_q  <= '0;
            mem_tag_q <= '0;
            wb_tag_q  <= '0;
            cnt_q     <= '0;
        end else begin
            ex_tag_q  <= ex_tag_d;
            ex_rs1_q  <= ex_rs1_d;
            ex_rs2_q  <= ex_rs2_d;
            mem_tag_q <= mem_tag_d;
            wb_tag_q  <= wb_tag_d;
            cnt_q     <= cnt_d;
        end
    end

    fwd_select u_fwd_a (
        .ex_valid_in (ex_tag_q.valid),
        .src_in      (ex_rs1_q),
        .mem_tag_in  (mem_tag_q),
        .wb_tag_in   (wb_tag_q),
        .sel_out     (fwd_a)
    );

    fwd_select u_fwd_b (
        .ex_valid_in (ex_tag_q.valid),
        .src_in      (ex_rs2_q),
        .mem_tag_in  (mem_tag_q),
        .wb_tag_in   (wb_tag_q),
        .sel_out     (fwd_b)
    );

    assign fwd_a_sel_out   = fwd_a;
    assign fwd_b_sel_out   = fwd_b;
    assign stall_out       = stall;
    assign ex_valid_out    = ex_tag_q.valid;
    assign stall_count_out = cnt_q;

    // The load-use stall keeps a load at least two slots ahead of its consumer.
    a_no_load_in_mem_hit: assert property (@(posedge clk_in) disable iff (rst_in)
        !(ex_tag_q.valid && mem_tag_q.valid && mem_tag_q.reg_write && mem_tag_q.mem_read &&
          mem_tag_q.rd != '0 && (mem_tag_q.rd == ex_rs1_q || mem_tag_q.rd == ex_rs2_q)));
endmodule
